// File: rtl/output_display_pkg.sv
// Shared types and constants for the output display: FSM states,
// seven-segment patterns, digit codes and the double-dabble step.
package output_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Segment patterns, active-high, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Digit codes beyond 0-9 understood by the encoder
    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_MINUS = 4'd11;

    // One double-dabble step on {hundreds, tens, ones, binary}:
    // bump every BCD nibble >= 5 by 3, then shift the whole word left.
    function automatic logic [19:0] dd_step(input logic [19:0] sr);
        logic [19:0] t;
        t = sr;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // Absolute value of an 8-bit byte; 0x80 negates to 0x80, read as 128
    function automatic logic [7:0] magnitude(input logic [7:0] d, input logic neg);
        return neg ? 8'(~d + 8'd1) : d;
    endfunction

endpackage

// File: rtl/output_display_seven_seg_encode.sv
// Combinational digit-code to seven-segment encoder.
// Codes 0-9 are decimal digits, 11 is a minus sign, anything else is blank.
module seven_seg_encode
    import output_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Look up the segment pattern for the selected digit code
    always_comb begin
        seg = SEG_BLANK;
        if (code <= 4'd9)
            seg = SEG_DIGIT[code];
        else if (code == CODE_MINUS)
            seg = SEG_MINUS;
    end

endmodule

// File: rtl/output_display.sv
// Output-register display: captures a CPU byte, converts it to BCD with a
// sequential double-dabble, and multiplexes four seven-segment digits.
// The display registers only update on a completed conversion.
module output_display
    import output_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       signedMode,
    output logic [7:0] value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

    state_t      state;
    state_t      next_state;
    logic        start;
    logic        do_shift;
    logic        do_commit;

    logic [2:0]  shift_cnt;
    logic [19:0] sr;
    logic        neg;
    logic [3:0]  bcd_hund;
    logic [3:0]  bcd_tens;
    logic [3:0]  bcd_ones;

    logic [3:0]  disp_ones;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_hund;
    logic [3:0]  disp_sign;

    logic [15:0] refresh_cnt;
    logic [1:0]  scan_idx;
    logic [3:0]  digit_code;

    assign bcd_hund = sr[19:16];
    assign bcd_tens = sr[15:12];
    assign bcd_ones = sr[11:8];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // FSM next state: a load in any state restarts the conversion
    always_comb begin
        next_state = state;
        if (load) begin
            next_state = SHIFT;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                SHIFT:   next_state = (shift_cnt == 3'd7) ? COMMIT : SHIFT;
                COMMIT:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // FSM outputs: a load overrides any shift or commit in progress
    always_comb begin
        start     = load;
        do_shift  = (state == SHIFT)  && !load;
        do_commit = (state == COMMIT) && !load;
        busy      = (state != IDLE);
    end

    // Capture, double-dabble shifting and display commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value     <= 8'h00;
            neg       <= 1'b0;
            sr        <= '0;
            shift_cnt <= '0;
            disp_ones <= 4'd0;
            disp_tens <= CODE_BLANK;
            disp_hund <= CODE_BLANK;
            disp_sign <= CODE_BLANK;
        end else if (start) begin
            value     <= data;
            neg       <= signedMode & data[7];
            sr        <= {12'd0, magnitude(data, signedMode & data[7])};
            shift_cnt <= '0;
        end else if (do_shift) begin
            sr        <= dd_step(sr);
            shift_cnt <= shift_cnt + 3'd1;
        end else if (do_commit) begin
            disp_ones <= bcd_ones;
            disp_tens <= (bcd_hund == 4'd0 && bcd_tens == 4'd0) ? CODE_BLANK : bcd_tens;
            disp_hund <= (bcd_hund == 4'd0) ? CODE_BLANK : bcd_hund;
            disp_sign <= neg ? CODE_MINUS : CODE_BLANK;
        end
    end

    // Free-running refresh divider and digit scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == DIV_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 16'd1;
        end
    end

    // Select the digit code for the active position and its anode
    always_comb begin
        case (scan_idx)
            2'd0:    digit_code = disp_ones;
            2'd1:    digit_code = disp_tens;
            2'd2:    digit_code = disp_hund;
            default: digit_code = disp_sign;
        endcase
        an = ~(4'b0001 << scan_idx);
    end

    seven_seg_encode u_encode (
        .code (digit_code),
        .seg  (seg)
    );

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display: stimulus pushes the expected display
// and busy length, a monitor pops and compares when a conversion finishes.
module tb_output_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data = 8'h00;
    logic       signedMode = 1'b0;
    logic [7:0] value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;

    typedef struct {
        logic [35:0] disp;      // {value, d3, d2, d1, d0}
        int          busy_len;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         pushed  = 0;
    int         checked = 0;
    logic [6:0] prev_d0 = 7'h3F;

    output_display #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .signedMode (signedMode),
        .value      (value),
        .busy       (busy),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;
            3: return 7'h4F;  4: return 7'h66;  5: return 7'h6D;
            6: return 7'h7D;  7: return 7'h07;  8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Reference: decimal arithmetic on the signed/unsigned interpretation
    function automatic logic [35:0] model(input logic [7:0] d, input logic sm);
        int m, h, t, o;
        logic isneg;
        logic [6:0] d3, d2, d1, d0;
        isneg = sm && d[7];
        m  = isneg ? 256 - int'(d) : int'(d);
        h  = m / 100;
        t  = (m / 10) % 10;
        o  = m % 10;
        d3 = isneg ? 7'h40 : 7'h00;
        d2 = (h != 0) ? seg_of(h) : 7'h00;
        d1 = (h != 0 || t != 0) ? seg_of(t) : 7'h00;
        d0 = seg_of(o);
        return {d, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic load_pulse(input logic [7:0] d, input logic sm);
        @(negedge clk);
        data = d;
        signedMode = sm;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic push_exp(input logic [35:0] disp, input int bl);
        exp_t e;
        e.disp = disp;
        e.busy_len = bl;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic wait_checked(input string name);
        int g;
        g = 0;
        while (checked < pushed && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (checked < pushed) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no commit seen, got %0d checked, want %0d", name, checked, pushed);
            sb.delete();
            checked = pushed;
        end
    endtask

    // Expects to be called on the negedge where rst was just released
    task automatic check_scan(input string name, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        for (int c = 0; c < 4 * DIV; c++) begin
            exp_an = ~(4'b0001 << (c / DIV));
            case (c / DIV)
                0:       exp_seg = d0;
                1:       exp_seg = d1;
                2:       exp_seg = d2;
                default: exp_seg = d3;
            endcase
            check(name, 36'({an, seg}), 36'({exp_an, exp_seg}));
            @(negedge clk);
        end
    endtask

    // Monitor: on busy falling, capture all four digits and compare
    initial begin
        logic       busy_prev;
        int         bcnt;
        logic [6:0] segs [4];
        exp_t       e;
        busy_prev = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
                bcnt = 0;
            end else if (busy) begin
                bcnt++;
                if (an == 4'b1110)
                    check("hold_d0", 36'(seg), 36'(prev_d0));
                busy_prev = 1'b1;
            end else if (busy_prev) begin
                for (int k = 0; k < 4; k++) segs[k] = 7'bx;
                for (int c = 0; c < 4 * DIV; c++) begin
                    if (c > 0) @(negedge clk);
                    case (an)
                        4'b1110: segs[0] = seg;
                        4'b1101: segs[1] = seg;
                        4'b1011: segs[2] = seg;
                        4'b0111: segs[3] = seg;
                        default: ;
                    endcase
                end
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_commit: got value %h, want no commit", value);
                end else begin
                    e = sb.pop_front();
                    check("display", {value, segs[3], segs[2], segs[1], segs[0]}, e.disp);
                    check("busy_len", 36'(bcnt), 36'(e.busy_len));
                    prev_d0 = e.disp[6:0];
                end
                checked++;
                busy_prev = 1'b0;
                bcnt = 0;
            end
        end
    end

    // Stimulus
    initial begin
        repeat (3) @(negedge clk);
        check("rst_an",    36'(an),    36'(4'b1110));
        check("rst_seg",   36'(seg),   36'(7'b0111111));
        check("rst_busy",  36'(busy),  36'(1'b0));
        check("rst_value", 36'(value), 36'(8'h00));
        rst = 1'b0;
        check_scan("scan_reset", 7'h00, 7'h00, 7'h00, 7'h3F);

        push_exp({8'hFF, 7'h00, 7'h5B, 7'h6D, 7'h6D}, 9);
        load_pulse(8'hFF, 1'b0);
        wait_checked("u255");

        push_exp({8'hFF, 7'h40, 7'h00, 7'h00, 7'h06}, 9);
        load_pulse(8'hFF, 1'b1);
        wait_checked("s_minus1");

        push_exp({8'h80, 7'h40, 7'h06, 7'h5B, 7'h7F}, 9);
        load_pulse(8'h80, 1'b1);
        wait_checked("s_minus128");

        // second load three edges after the first wins
        push_exp({8'h2A, 7'h00, 7'h00, 7'h66, 7'h5B}, 12);
        load_pulse(8'h07, 1'b0);
        @(negedge clk);
        load_pulse(8'h2A, 1'b0);
        wait_checked("restart42");

        // reset in the middle of a conversion
        load_pulse(8'h64, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",  36'(busy),  36'(1'b0));
        check("abort_value", 36'(value), 36'(8'h00));
        @(negedge clk);
        @(negedge clk);
        prev_d0 = 7'h3F;
        rst = 1'b0;
        check_scan("scan_abort", 7'h00, 7'h00, 7'h00, 7'h3F);

        for (int sm = 0; sm < 2; sm++) begin
            for (int d = 0; d < 256; d++) begin
                push_exp(model(8'(d), sm[0]), 9);
                load_pulse(8'(d), sm[0]);
                wait_checked("sweep");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, want finish before 60000 cycles");
        $fatal(1);
    end

endmodule
